multi_clock_divider: RTL and testbench

- Parametrised successor to the single fixed-rate divider: P_CHANNELS independent divided clocks from one system clock.
- Each channel's half-period divisor is runtime-programmable through a valid/ready load port, with glitch-free changeover.
- Each channel also provides a one-cycle tick at every rising edge of its output.
- Feeds LED blinkers, 7-segment multiplexers and UART-rate strobes.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_channel.sv | 89 ++++++++
 rtl/multi_clock_divider.sv | 67 ++++++
 tb/tb_multi_clock_divider.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Used by multi_clock_divider and clk_div_channel.
package clk_div_pkg;

    localparam int CLK_HZ       = 50000000;
    localparam int MAX_CHANNELS = 16;

    // Half-period divisor that yields an output of hz from CLK_HZ.
    function automatic int freq_to_div(input int hz);
        return CLK_HZ / (2 * hz);
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: counter, output/tick registers and the
// active/pending divisor pair with glitch-free changeover at wraps.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int P_CNT_W       = 26,
    parameter int P_DEFAULT_DIV = 25000000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               sync_i,
    input  logic               load_i,
    input  logic [P_CNT_W-1:0] load_div_i,
    output logic               pend_o,
    output logic               clk_o,
    output logic               tick_o
);

    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic [P_CNT_W-1:0] div_q, div_d;
    logic [P_CNT_W-1:0] pdiv_q, pdiv_d;
    logic               pend_q, pend_d;
    logic               oclk_q, oclk_d;
    logic               tick_q, tick_d;
    logic               park;
    logic               wrap;
    logic               apply;

    // Next-state: park/sync clear, wrap toggles, pending applies at safe points.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        oclk_d = oclk_q;
        tick_d = 1'b0;
        park   = ~en_i | (div_q == '0);
        wrap   = ~park & (cnt_q == (div_q - P_CNT_W'(1)));
        apply  = pend_q & (sync_i | park | wrap);

        if (sync_i | park) begin
            cnt_d  = '0;
            oclk_d = 1'b0;
        end else if (wrap) begin
            cnt_d  = '0;
            oclk_d = ~oclk_q;
            tick_d = ~oclk_q;
        end else begin
            cnt_d  = cnt_q + P_CNT_W'(1);
        end

        if (apply) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
        end

        // Accept only happens while nothing is pending, so it never
        // collides with an apply on the same channel.
        if (load_i) begin
            pdiv_d = load_div_i;
            pend_d = 1'b1;
        end
    end

    // State registers with synchronous reset to the default divisor.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            div_q  <= P_CNT_W'(P_DEFAULT_DIV);
            pdiv_q <= '0;
            pend_q <= 1'b0;
            oclk_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            oclk_q <= oclk_d;
            tick_q <= tick_d;
        end
    end

    assign pend_o = pend_q;
    assign clk_o  = oclk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// P_CHANNELS independent divided clocks with a valid/ready divisor load port.
// Optional macro MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN adds i_sync phase alignment.
module multi_clock_divider
    import clk_div_pkg::*;
#(
    parameter int  P_CHANNELS    = 4,
    parameter int  P_CNT_W       = 26,
    parameter int  P_DEFAULT_DIV = 25000000,
    localparam int CH_W          = ch_width(P_CHANNELS)
) (
    input  logic                  i_clk,
    input  logic                  reset,
    input  logic [P_CHANNELS-1:0] i_en,
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
    input  logic                  i_sync,
`endif
    input  logic                  i_load_valid,
    input  logic [CH_W-1:0]       i_load_ch,
    input  logic [P_CNT_W-1:0]    i_load_div,
    output logic                  o_load_ready,
    output logic [P_CHANNELS-1:0] o_clk,
    output logic [P_CHANNELS-1:0] o_tick
);

    localparam int NPAD = 1 << CH_W;

    logic [P_CHANNELS-1:0] pend;
    logic [P_CHANNELS-1:0] load_we;
    logic [NPAD-1:0]       pend_pad;
    logic                  accept;
    logic                  sync;

`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
    assign sync = i_sync;
`else
    assign sync = 1'b0;
`endif

    // Unused channel codes read as never-pending, so they stay ready.
    always_comb begin
        pend_pad                 = '0;
        pend_pad[P_CHANNELS-1:0] = pend;
    end

    assign o_load_ready = ~pend_pad[i_load_ch];
    assign accept       = i_load_valid & o_load_ready;

    for (genvar g = 0; g < P_CHANNELS; g++) begin : g_ch
        assign load_we[g] = accept & (i_load_ch == CH_W'(g));

        clk_div_channel #(
            .P_CNT_W      (P_CNT_W),
            .P_DEFAULT_DIV(P_DEFAULT_DIV)
        ) u_ch (
            .clk_i     (i_clk),
            .rst_i     (reset),
            .en_i      (i_en[g]),
            .sync_i    (sync),
            .load_i    (load_we[g]),
            .load_div_i(i_load_div),
            .pend_o    (pend[g]),
            .clk_o     (o_clk[g]),
            .tick_o    (o_tick[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: directed table, corner
// sequences and randomized traffic against a phase/age reference model.
module tb_multi_clock_divider;

    localparam int N    = 5;
    localparam int W    = 26;
    localparam int DEF  = 25000000;
    localparam int CHW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   en;
    logic           sync_v;
    logic           vld;
    logic [CHW-1:0] lch;
    logic [W-1:0]   ldiv;
    logic           rdy;
    logic [N-1:0]   oclk;
    logic [N-1:0]   otick;
    logic           rdy_s;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: each channel is a level base plus an age counted
    // since its current divisor took effect; toggles = age / D.
    int m_age  [N];
    int m_base [N];
    int m_d    [N];
    int m_pend [N];
    int m_pdiv [N];
    int m_tick [N];

    always #5 clk = ~clk;

    multi_clock_divider #(
        .P_CHANNELS   (N),
        .P_CNT_W      (W),
        .P_DEFAULT_DIV(DEF)
    ) dut (
        .i_clk       (clk),
        .reset       (rst),
        .i_en        (en),
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
        .i_sync      (sync_v),
`endif
        .i_load_valid(vld),
        .i_load_ch   (lch),
        .i_load_div  (ldiv),
        .o_load_ready(rdy),
        .o_clk       (oclk),
        .o_tick      (otick)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int m_clk(input int c);
        if (m_d[c] == 0) return m_base[c];
        return m_base[c] ^ ((m_age[c] / m_d[c]) & 1);
    endfunction

    function automatic int m_rdy();
        if (int'(lch) >= N) return 1;
        return (m_pend[lch] == 0) ? 1 : 0;
    endfunction

    task automatic model_step();
        int acc;
        int cur;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_age[c]  = 0;
                m_base[c] = 0;
                m_d[c]    = DEF;
                m_pend[c] = 0;
                m_pdiv[c] = 0;
                m_tick[c] = 0;
                continue;
            end
            acc = (vld && int'(lch) == c && m_pend[c] == 0) ? 1 : 0;
            if (sync_v || !en[c] || m_d[c] == 0) begin
                if (m_pend[c] != 0) begin
                    m_d[c]    = m_pdiv[c];
                    m_pend[c] = 0;
                end
                m_age[c]  = 0;
                m_base[c] = 0;
                m_tick[c] = 0;
            end else begin
                m_age[c]++;
                if (m_age[c] % m_d[c] == 0) begin
                    cur       = m_clk(c);
                    m_tick[c] = cur;
                    if (m_pend[c] != 0) begin
                        m_base[c] = cur;
                        m_age[c]  = 0;
                        m_d[c]    = m_pdiv[c];
                        m_pend[c] = 0;
                    end
                end else begin
                    m_tick[c] = 0;
                end
            end
            if (acc != 0) begin
                m_pend[c] = 1;
                m_pdiv[c] = int'(ldiv);
            end
        end
    endtask

    // One clock: check ready before the edge, step model, check after.
    task automatic tick_cycle(output logic r);
        #1;
        r = rdy;
        chk("ready", int'(rdy), m_rdy());
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            chk($sformatf("clk%0d", c), int'(oclk[c]), m_clk(c));
            chk($sformatf("tick%0d", c), int'(otick[c]), m_tick[c]);
        end
    endtask

    task automatic load_parked(input int c, input int d);
        en[c] = 1'b0;
        vld   = 1'b1;
        lch   = CHW'(c);
        ldiv  = W'(d);
        tick_cycle(rdy_s);
        vld   = 1'b0;
        tick_cycle(rdy_s);
    endtask

    task automatic wait_tick(input int c, input int lim, input string nm);
        bit hit = 0;
        for (int i = 0; i < lim && !hit; i++) begin
            tick_cycle(rdy_s);
            if (otick[c]) hit = 1;
        end
        chk(nm, int'(hit), 1);
    endtask

    task automatic wait_rise(input int c, input int exp, input string nm);
        bit hit = 0;
        int n = 0;
        for (int i = 0; i < exp + 20 && !hit; i++) begin
            tick_cycle(rdy_s);
            n++;
            if (oclk[c]) hit = 1;
        end
        chk(nm, hit ? n : -1, exp);
    endtask

    typedef struct {
        logic [N-1:0]   en;
        logic           vld;
        logic [CHW-1:0] ch;
        logic [W-1:0]   div;
        logic           clk0;
        logic           tick0;
        logic           rdy;
    } vec_t;

    vec_t vt [12];
    int   pat_clk [11];
    int   pat_rdy [11];

    initial begin
        // en, vld, ch, div -> clk0, tick0, ready-before-edge
        vt[0]  = '{5'b00000, 1'b1, 3'd0, 26'd3, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{5'b00000, 1'b0, 3'd0, 26'd0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b1, 1'b1, 1'b1};
        vt[5]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b0, 1'b0, 1'b1};
        vt[10] = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b1, 1'b1, 1'b1};
        vt[11] = '{5'b00001, 1'b0, 3'd0, 26'd0, 1'b1, 1'b0, 1'b1};
        pat_clk = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        pat_rdy = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

        rst    = 1'b1;
        en     = '0;
        sync_v = 1'b0;
        vld    = 1'b0;
        lch    = '0;
        ldiv   = '0;
        for (int c = 0; c < N; c++) begin
            m_age[c] = 0; m_base[c] = 0; m_d[c] = DEF;
            m_pend[c] = 0; m_pdiv[c] = 0; m_tick[c] = 0;
        end
        @(posedge clk);
        #1;
        tick_cycle(rdy_s);
        tick_cycle(rdy_s);
        chk("reset_clk", int'(oclk), 0);
        chk("reset_tick", int'(otick), 0);
        rst = 1'b0;
        #1;
        chk("reset_ready", int'(rdy), 1);

        // Directed table: ch0 D=3, rises at 3 and 9, falls at 6.
        for (int i = 0; i < 12; i++) begin
            en   = vt[i].en;
            vld  = vt[i].vld;
            lch  = vt[i].ch;
            ldiv = vt[i].div;
            tick_cycle(rdy_s);
            chk($sformatf("tbl%0d_rdy", i), int'(rdy_s), int'(vt[i].rdy));
            chk($sformatf("tbl%0d_clk", i), int'(oclk[0]), int'(vt[i].clk0));
            chk($sformatf("tbl%0d_tick", i), int'(otick[0]), int'(vt[i].tick0));
        end

        // ch1 D=2, reload D=5 at the start of a high half.
        load_parked(1, 2);
        en[1] = 1'b1;
        wait_tick(1, 20, "ch1_tick");
        vld  = 1'b1;
        lch  = 3'd1;
        ldiv = 26'd5;
        tick_cycle(rdy_s);
        chk("ch1_acc_rdy", int'(rdy_s), 1);
        chk("ch1_high2", int'(oclk[1]), 1);
        vld = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick_cycle(rdy_s);
            chk($sformatf("ch1_pat%0d", i), int'(oclk[1]), pat_clk[i]);
            chk($sformatf("ch1_rdy%0d", i), int'(rdy_s), pat_rdy[i]);
        end

        // ch2: valid held while pending, only the first value takes.
        en[2] = 1'b1;
        vld   = 1'b1;
        lch   = 3'd2;
        ldiv  = 26'd7;
        tick_cycle(rdy_s);
        chk("ch2_first_rdy", int'(rdy_s), 1);
        ldiv = 26'd9;
        for (int i = 0; i < 3; i++) begin
            tick_cycle(rdy_s);
            chk($sformatf("ch2_held_rdy%0d", i), int'(rdy_s), 0);
        end
        vld   = 1'b0;
        en[2] = 1'b0;
        tick_cycle(rdy_s);
        chk("ch2_apply_rdy", int'(rdy_s), 0);
        tick_cycle(rdy_s);
        chk("ch2_after_rdy", int'(rdy_s), 1);
        en[2] = 1'b1;
        wait_rise(2, 7, "ch2_rise");

        // Out-of-range channel: always ready, nothing changes.
        vld  = 1'b1;
        lch  = 3'd7;
        ldiv = 26'd1;
        tick_cycle(rdy_s);
        chk("ch7_rdy0", int'(rdy_s), 1);
        tick_cycle(rdy_s);
        chk("ch7_rdy1", int'(rdy_s), 1);
        vld = 1'b0;

        // ch0 D=0 load in a high half parks the channel after the wrap.
        wait_tick(0, 20, "ch0_tick");
        vld  = 1'b1;
        lch  = 3'd0;
        ldiv = 26'd0;
        tick_cycle(rdy_s);
        vld = 1'b0;
        tick_cycle(rdy_s);
        for (int i = 0; i < 10; i++) begin
            tick_cycle(rdy_s);
            chk($sformatf("ch0_park_clk%0d", i), int'(oclk[0]), 0);
            chk($sformatf("ch0_park_tick%0d", i), int'(otick[0]), 0);
        end
        vld  = 1'b1;
        ldiv = 26'd4;
        tick_cycle(rdy_s);
        vld = 1'b0;
        tick_cycle(rdy_s);
        wait_rise(0, 4, "ch0_resume");

        // ch3 D=10: drop en in a high half, then restart.
        load_parked(3, 10);
        en[3] = 1'b1;
        wait_tick(3, 30, "ch3_tick");
        tick_cycle(rdy_s);
        tick_cycle(rdy_s);
        en[3] = 1'b0;
        tick_cycle(rdy_s);
        chk("ch3_drop", int'(oclk[3]), 0);
        en[3] = 1'b1;
        wait_rise(3, 10, "ch3_restart");

        // Reset mid-run with a pending load on ch3.
        vld  = 1'b1;
        lch  = 3'd3;
        ldiv = 26'd2;
        tick_cycle(rdy_s);
        vld = 1'b0;
        rst = 1'b1;
        tick_cycle(rdy_s);
        chk("rst_pend_rdy", int'(rdy_s), 0);
        chk("rst_clk", int'(oclk), 0);
        rst = 1'b0;
        tick_cycle(rdy_s);
        chk("rst_cleared_rdy", int'(rdy_s), 1);
        en = '1;
        for (int i = 0; i < 40; i++) begin
            tick_cycle(rdy_s);
            chk($sformatf("rst_def%0d", i), int'(oclk), 0);
        end

`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
        en = '0;
        load_parked(0, 3);
        load_parked(1, 5);
        en = 5'b00011;
        for (int i = 0; i < 13; i++) tick_cycle(rdy_s);
        sync_v = 1'b1;
        tick_cycle(rdy_s);
        sync_v = 1'b0;
        chk("sync_clk", int'(oclk[1:0]), 0);
        begin
            int r0 = -1;
            int r1 = -1;
            for (int i = 1; i <= 20; i++) begin
                tick_cycle(rdy_s);
                if (r0 < 0 && oclk[0]) r0 = i;
                if (r1 < 0 && oclk[1]) r1 = i;
            end
            chk("sync_rise0", r0, 3);
            chk("sync_rise1", r1, 5);
        end
        rst    = 1'b1;
        sync_v = 1'b1;
        tick_cycle(rdy_s);
        chk("rst_sync_clk", int'(oclk), 0);
        chk("rst_sync_tick", int'(otick), 0);
        rst    = 1'b0;
        sync_v = 1'b0;
        tick_cycle(rdy_s);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                en[$urandom_range(0, N - 1)] ^= 1'b1;
            vld  = ($urandom_range(0, 3) == 0);
            lch  = CHW'($urandom_range(0, 7));
            ldiv = W'($urandom_range(0, 6));
            rst  = ($urandom_range(0, 999) == 0);
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
            sync_v = ($urandom_range(0, 199) == 0);
`endif
            tick_cycle(rdy_s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
